// File: rtl/stopwatch_ctrl.sv
// Stopwatch control front-end: button sync/debounce, start/stop/lap FSM,
// lap register and live/lap display select.
module stopwatch_ctrl #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic [23:0] time_in,
  output logic        run,
  output logic        clr,
  output logic        lap_active,
  output logic [23:0] disp
);

  localparam int unsigned CNT_W  = $clog2(DB_CYCLES + 1);
  localparam int unsigned NBTN   = 2;
  localparam int unsigned TIME_W = 24;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  // Button index 0 is start/stop, index 1 is lap/reset.
  logic [NBTN-1:0]  btn_raw;
  logic [NBTN-1:0]  meta_q, sync_q;
  logic [NBTN-1:0]  db_q, db_d;
  logic [NBTN-1:0]  evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q [NBTN];
  logic [CNT_W-1:0] cnt_d [NBTN];

  logic ss_evt, lr_evt;

  state_e            state_q, state_d;
  logic              clr_q, clr_d;
  logic [TIME_W-1:0] lap_q, lap_d;

  assign btn_raw = {btn_lr, btn_ss};

  // Debounce: a level change is accepted only after DB_CYCLES stable mismatching cycles.
  always_comb begin
    db_d  = db_q;
    evt_d = '0;
    for (int i = 0; i < int'(NBTN); i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
          db_d[i]  = sync_q[i];
          evt_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      db_q   <= '0;
      evt_q  <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      meta_q <= btn_raw;
      sync_q <= meta_q;
      db_q   <= db_d;
      evt_q  <= evt_d;
      for (int i = 0; i < int'(NBTN); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Start/stop wins when both presses land in the same cycle.
  assign ss_evt = evt_q[0];
  assign lr_evt = evt_q[1] & ~evt_q[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      clr_q   <= 1'b0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      lap_q   <= lap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    lap_d   = lap_q;
    case (state_q)
      S_IDLE: begin
        if (ss_evt) begin
          state_d = S_RUN;
        end else if (lr_evt) begin
          clr_d = 1'b1;
        end
      end
      S_RUN: begin
        if (ss_evt) begin
          state_d = S_PAUSE;
        end else if (lr_evt) begin
          state_d = S_LAP;
          lap_d   = time_in;
        end
      end
      S_LAP: begin
        if (ss_evt) begin
          state_d = S_PAUSE;
        end else if (lr_evt) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (ss_evt) begin
          state_d = S_RUN;
        end else if (lr_evt) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    run        = (state_q == S_RUN) || (state_q == S_LAP);
    lap_active = (state_q == S_LAP);
    clr        = clr_q;
    disp       = lap_active ? lap_q : time_in;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with a short debounce window.
module tb_stopwatch_ctrl;

  localparam int unsigned DB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_ss;
  logic        btn_lr;
  logic [23:0] time_in;
  logic        run;
  logic        clr;
  logic        lap_active;
  logic [23:0] disp;

  typedef struct {
    string       tag;
    logic        run;
    logic        clr;
    logic        lap;
    logic [23:0] disp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   clr_total  = 0;
  int   clr_double = 0;
  logic clr_prev   = 1'b0;

  stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_ss     (btn_ss),
    .btn_lr     (btn_lr),
    .time_in    (time_in),
    .run        (run),
    .clr        (clr),
    .lap_active (lap_active),
    .disp       (disp)
  );

  always #5 clk = ~clk;

  // Count clear pulses and back-to-back clear cycles.
  always @(negedge clk) begin
    if (clr) clr_total <= clr_total + 1;
    if (clr && clr_prev) clr_double <= clr_double + 1;
    clr_prev <= clr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic r, input logic l, input logic [23:0] d);
    exp_t e;
    e.tag  = tag;
    e.run  = r;
    e.clr  = 1'b0;
    e.lap  = l;
    e.disp = d;
    sb.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".run"},  32'(run),        32'(e.run));
    check({e.tag, ".clr"},  32'(clr),        32'(e.clr));
    check({e.tag, ".lap"},  32'(lap_active), 32'(e.lap));
    check({e.tag, ".disp"}, 32'(disp),       32'(e.disp));
  endtask

  task automatic press(input logic ss, input logic lr, input int hold);
    @(negedge clk);
    btn_ss = ss;
    btn_lr = lr;
    repeat (hold) @(negedge clk);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Hold start/stop from the next edge and return how many edges until run rises (0 = never).
  task automatic measure_run_rise(output int lat);
    lat = 0;
    btn_ss = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (run && lat == 0) lat = i;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int c0;
    int d0;
    reset   = 1'b1;
    btn_ss  = 1'b0;
    btn_lr  = 1'b0;
    time_in = 24'h000000;
    repeat (3) @(negedge clk);
    expect_out("reset", 1'b0, 1'b0, 24'h000000);
    score();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Bouncing start/stop shorter than the debounce window.
    for (int k = 0; k < 4; k++) begin
      btn_ss = (k % 2 == 0);
      repeat (2) @(negedge clk);
    end
    btn_ss = 1'b0;
    repeat (12) @(negedge clk);
    expect_out("bounce", 1'b0, 1'b0, 24'h000000);
    score();

    // Clean start press: latency 2 sync + DB + 1.
    time_in = 24'h000100;
    measure_run_rise(lat);
    check("start_latency", 32'(lat >= 6 && lat <= 8), 32'd1);
    btn_ss = 1'b0;
    repeat (12) @(negedge clk);
    expect_out("start", 1'b1, 1'b0, 24'h000100);
    score();

    // Counter wrap is transparent.
    time_in = 24'h235959;
    @(negedge clk);
    time_in = 24'h000000;
    repeat (2) @(negedge clk);
    expect_out("wrap", 1'b1, 1'b0, 24'h000000);
    score();

    // Lap freeze and release.
    time_in = 24'h012345;
    press(1'b0, 1'b1, 12);
    expect_out("lap_on", 1'b1, 1'b1, 24'h012345);
    score();
    time_in = 24'h012350;
    @(negedge clk);
    expect_out("lap_frozen", 1'b1, 1'b1, 24'h012345);
    score();
    press(1'b0, 1'b1, 12);
    expect_out("lap_off", 1'b1, 1'b0, 24'h012350);
    score();
    time_in = 24'h012351;
    @(negedge clk);
    expect_out("live", 1'b1, 1'b0, 24'h012351);
    score();

    // Pause then reset to idle with a single clear pulse.
    press(1'b1, 1'b0, 12);
    expect_out("pause", 1'b0, 1'b0, 24'h012351);
    score();
    c0 = clr_total;
    d0 = clr_double;
    press(1'b0, 1'b1, 12);
    check("pause_clr_count", 32'(clr_total - c0), 32'd1);
    check("pause_clr_double", 32'(clr_double - d0), 32'd0);
    expect_out("idle", 1'b0, 1'b0, 24'h012351);
    score();

    // Lap/reset in idle clears again and stays idle.
    c0 = clr_total;
    press(1'b0, 1'b1, 12);
    check("idle_clr_count", 32'(clr_total - c0), 32'd1);
    expect_out("idle_clr", 1'b0, 1'b0, 24'h012351);
    score();

    // Simultaneous presses from RUN: start/stop wins.
    time_in = 24'h024680;
    press(1'b1, 1'b0, 12);
    expect_out("run2", 1'b1, 1'b0, 24'h024680);
    score();
    c0 = clr_total;
    press(1'b1, 1'b1, 12);
    check("both_clr_count", 32'(clr_total - c0), 32'd0);
    expect_out("both", 1'b0, 1'b0, 24'h024680);
    score();

    // Resume without clear, then lap, then reset mid-debounce.
    c0 = clr_total;
    press(1'b1, 1'b0, 12);
    check("resume_clr_count", 32'(clr_total - c0), 32'd0);
    expect_out("resume", 1'b1, 1'b0, 24'h024680);
    score();
    time_in = 24'h111111;
    press(1'b0, 1'b1, 12);
    time_in = 24'h111112;
    @(negedge clk);
    expect_out("lap2", 1'b1, 1'b1, 24'h111111);
    score();
    btn_ss = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    expect_out("async_reset", 1'b0, 1'b0, 24'h111112);
    score();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    measure_run_rise(lat);
    check("post_reset_latency", 32'(lat >= 6 && lat <= 8), 32'd1);
    btn_ss = 1'b0;
    repeat (12) @(negedge clk);
    expect_out("post_reset_run", 1'b1, 1'b0, 24'h111112);
    score();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
